// File: rtl/mockingboard_audio_resampler.sv
// Mockingboard PSG mix to 16-bit stereo PCM: oversampled one-pole low-pass,
// DC tracker, saturating output stage and a 4-entry first-word fall-through FIFO.
module mockingboard_audio_resampler #(
  parameter int CLK_HZ      = 54_000_000,
  parameter int SAMPLE_RATE = 48_000,
  parameter int OVS_DIV     = 64,
  parameter int LP_SHIFT    = 4,
  parameter int DC_SHIFT    = 10
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic [9:0]  audio_l_i,
  input  logic [9:0]  audio_r_i,
  input  logic        mute_i,
  output logic [15:0] sample_l_o,
  output logic [15:0] sample_r_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        sample_tick_o,
  output logic        overflow_o
);

  localparam int CNT_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVS_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [32:0] CLK_HZ_W = 33'(CLK_HZ);
  localparam logic [32:0] SR_W     = 33'(SAMPLE_RATE);

  // Unsigned mix code to signed 16-bit, centred on code 384.
  function automatic logic signed [15:0] scale16(input logic [9:0] a, input logic mute);
    logic [9:0]         x;
    logic signed [15:0] t;
    x = mute ? 10'd384 : a;
    t = $signed({6'd0, x}) - 16'sd384;
    return t <<< 6;
  endfunction

  function automatic logic signed [23:0] lp_step(input logic signed [23:0] y,
                                                 input logic signed [15:0] xs);
    logic signed [24:0] diff;
    logic signed [24:0] sum;
    diff = $signed({xs[15], xs, 8'd0}) - $signed({y[23], y});
    diff = diff >>> LP_SHIFT;
    sum  = $signed({y[23], y}) + diff;
    return sum[23:0];
  endfunction

  function automatic logic signed [23:0] dc_step(input logic signed [23:0] dc,
                                                 input logic signed [24:0] d);
    logic signed [24:0] sh;
    logic signed [24:0] sum;
    sh  = d >>> DC_SHIFT;
    sum = $signed({dc[23], dc}) + sh;
    return sum[23:0];
  endfunction

  // Drop the 8 fraction bits and clamp to the PCM range.
  function automatic logic signed [15:0] sat16(input logic signed [24:0] d);
    logic signed [16:0] s;
    s = d[24:8];
    if (s > 17'sd32767) begin
      return 16'sh7fff;
    end else if (s < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return s[15:0];
    end
  endfunction

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        acc_q, acc_d;
  logic signed [23:0] y_q [2];
  logic signed [23:0] y_d [2];
  logic signed [23:0] dc_q [2];
  logic signed [23:0] dc_d [2];
  logic signed [24:0] d1_q [2];
  logic signed [24:0] d1_d [2];
  logic signed [15:0] p2_q [2];
  logic signed [15:0] p2_d [2];
  logic               v1_q, v1_d, v2_q, v2_d;
  logic [31:0]        mem_q [4];
  logic [31:0]        mem_d [4];
  logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         count_q, count_d;
  logic [31:0]        head_q, head_d;
  logic               valid_q, valid_d, overflow_q, overflow_d;

  logic               strobe_s, tick_s, pop_s, full_s, push_s;
  logic [32:0]        acc_n_s, acc_w_s;
  logic signed [15:0] xs_s [2];
  logic signed [24:0] dlt_s [2];
  logic [31:0]        push_word_s;

  // Strobe/tick timing and the per-channel filter and output pipeline.
  always_comb begin
    strobe_s = (cnt_q == CNT_MAX);
    cnt_d    = strobe_s ? '0 : cnt_q + CNT_ONE;
    acc_n_s  = {1'b0, acc_q} + SR_W;
    acc_w_s  = acc_n_s - CLK_HZ_W;
    tick_s   = (acc_n_s >= CLK_HZ_W);
    acc_d    = tick_s ? acc_w_s[31:0] : acc_n_s[31:0];
    for (int ch = 0; ch < 2; ch++) begin
      xs_s[ch]  = scale16((ch == 0) ? audio_l_i : audio_r_i, mute_i);
      // The tick reads y before any coincident strobe update.
      dlt_s[ch] = $signed({y_q[ch][23], y_q[ch]}) - $signed({dc_q[ch][23], dc_q[ch]});
      y_d[ch]   = strobe_s ? lp_step(y_q[ch], xs_s[ch]) : y_q[ch];
      dc_d[ch]  = tick_s ? dc_step(dc_q[ch], dlt_s[ch]) : dc_q[ch];
      d1_d[ch]  = tick_s ? dlt_s[ch] : d1_q[ch];
      p2_d[ch]  = v1_q ? sat16(d1_q[ch]) : p2_q[ch];
    end
    v1_d = tick_s;
    v2_d = v1_q;
  end

  // FIFO bookkeeping; the head register holds its last value while empty.
  always_comb begin
    push_word_s = {p2_q[0], p2_q[1]};
    pop_s       = valid_q && sample_ready_i;
    full_s      = (count_q == 3'd4);
    push_s      = v2_q && (!full_s || pop_s);
    overflow_d  = overflow_q || (v2_q && full_s && !pop_s);
    wr_ptr_d    = push_s ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d    = pop_s ? rd_ptr_q + 2'd1 : rd_ptr_q;
    count_d     = count_q + {2'd0, push_s} - {2'd0, pop_s};
    mem_d       = mem_q;
    mem_d[wr_ptr_q] = push_s ? push_word_s : mem_q[wr_ptr_q];
    valid_d     = (count_d != 3'd0);
    if (count_d == 3'd0) begin
      head_d = head_q;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_word_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // State register.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= 32'd0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      head_q     <= 32'd0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        y_q[ch]  <= 24'sd0;
        dc_q[ch] <= 24'sd0;
        d1_q[ch] <= 25'sd0;
        p2_q[ch] <= 16'sd0;
      end
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      y_q        <= y_d;
      dc_q       <= dc_d;
      d1_q       <= d1_d;
      p2_q       <= p2_d;
      mem_q      <= mem_d;
    end
  end

  assign sample_l_o     = head_q[31:16];
  assign sample_r_o     = head_q[15:0];
  assign sample_valid_o = valid_q;
  assign overflow_o     = overflow_q;
  assign sample_tick_o  = tick_s;

endmodule

// File: tb/tb_mockingboard_audio_resampler.sv
// Randomized bench for mockingboard_audio_resampler, compared every cycle
// against an arithmetic reference model of the sample stream.
module tb_mockingboard_audio_resampler;
  localparam longint CLK_HZ = 54_000_000;
  localparam longint SR     = 48_000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  aud_l = 10'd384, aud_r = 10'd384;
  logic        mute = 1'b0, ready = 1'b1;
  logic [15:0] sample_l_o, sample_r_o;
  logic        sample_valid_o, sample_tick_o, overflow_o;

  always #5 clk = ~clk;

  mockingboard_audio_resampler dut (
    .clk_logic(clk), .reset(reset), .audio_l_i(aud_l), .audio_r_i(aud_r),
    .mute_i(mute), .sample_l_o(sample_l_o), .sample_r_o(sample_r_o),
    .sample_valid_o(sample_valid_o), .sample_ready_i(ready),
    .sample_tick_o(sample_tick_o), .overflow_o(overflow_o)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0t)", tag, obs, exp, $time);
      if (n_errors >= 300) begin
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { longint due; longint l; longint r; } pend_t;
  pend_t  pend_q[$];
  longint fq_l[$], fq_r[$];
  longint y[2], dc[2];
  longint last_l = 0, last_r = 0;
  longint cyc = 1;
  bit     m_ovf = 0;

  function automatic bit is_tick(input longint c);
    return ((c * SR) / CLK_HZ) != (((c - 1) * SR) / CLK_HZ);
  endfunction

  function automatic longint xs_of(input longint a, input bit m);
    longint x;
    x = m ? 384 : a;
    return (x - 384) * 64;
  endfunction

  function automatic longint sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_advance();
    longint s[2];
    longint d;
    pend_t  pe;
    bit     pop;
    if (reset) begin
      pend_q.delete(); fq_l.delete(); fq_r.delete();
      y = '{0, 0}; dc = '{0, 0};
      last_l = 0; last_r = 0; m_ovf = 0; cyc = 1;
      return;
    end
    pop = (fq_l.size() > 0) && ready;
    if (pop) begin
      void'(fq_l.pop_front());
      void'(fq_r.pop_front());
    end
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      pe = pend_q.pop_front();
      if (fq_l.size() < 4) begin
        fq_l.push_back(pe.l);
        fq_r.push_back(pe.r);
      end else begin
        m_ovf = 1;
      end
    end
    if (fq_l.size() > 0) begin
      last_l = fq_l[0];
      last_r = fq_r[0];
    end
    if (is_tick(cyc)) begin
      for (int ch = 0; ch < 2; ch++) begin
        d = y[ch] - dc[ch];
        s[ch] = sat(d >>> 8);
        dc[ch] += d >>> 10;
      end
      pend_q.push_back('{cyc + 2, s[0], s[1]});
    end
    if (cyc % 64 == 0) begin
      y[0] += ((xs_of(aud_l, mute) * 256) - y[0]) >>> 4;
      y[1] += ((xs_of(aud_r, mute) * 256) - y[1]) >>> 4;
    end
    cyc++;
  endfunction

  // One clock: advance the model on the current inputs, then compare outputs.
  task automatic cycle_();
    model_advance();
    @(negedge clk);
    check_eq("tick", longint'(sample_tick_o), longint'(is_tick(cyc)));
    check_eq("valid", longint'(sample_valid_o), longint'(fq_l.size() > 0));
    check_eq("overflow", longint'(overflow_o), longint'(m_ovf));
    check_eq("left", longint'($signed(sample_l_o)), last_l);
    check_eq("right", longint'($signed(sample_r_o)), last_r);
  endtask

  task automatic run_ticks(input int n, input bit rnd, output longint first_cyc);
    int seen;
    seen = 0;
    first_cyc = -1;
    for (int i = 0; i < n * 1125 + 50 && seen < n; i++) begin
      if (rnd) begin
        aud_l = 10'($urandom_range(0, 765));
        aud_r = 10'($urandom_range(0, 765));
        mute  = ($urandom_range(0, 7) == 0);
        ready = $urandom_range(0, 1) != 0;
      end
      cycle_();
      if (sample_tick_o) begin
        if (seen == 0) first_cyc = cyc;
        seen++;
      end
    end
    check_eq("tick_budget", seen, n);
  endtask

  task automatic count_pops(input int ncyc, output int pops);
    pops = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (sample_valid_o && ready) pops++;
      cycle_();
    end
  endtask

  initial begin
    longint fc;
    int     pops;
    @(negedge clk);
    cycle_();
    cycle_();
    reset = 1'b0;

    // Idle midpoint input: silent samples, tick cadence.
    run_ticks(4, 1'b0, fc);
    check_eq("first_tick_cycle", fc, 1125);
    check_eq("idle_overflow", longint'(overflow_o), 0);

    // Left step to full scale.
    aud_l = 10'd765;
    run_ticks(12, 1'b0, fc);
    check_eq("step_left_positive", longint'($signed(sample_l_o) > 0), 1);

    // Drain, then stall the consumer across six ticks of zero input.
    for (int i = 0; i < 4; i++) cycle_();
    ready = 1'b0; aud_l = 10'd0; aud_r = 10'd0;
    run_ticks(6, 1'b0, fc);
    for (int i = 0; i < 3; i++) cycle_();
    check_eq("stall_valid", longint'(sample_valid_o), 1);
    check_eq("stall_overflow", longint'(overflow_o), 1);
    check_eq("stall_left_negative", longint'($signed(sample_l_o) < 0), 1);
    ready = 1'b1;
    count_pops(12, pops);
    check_eq("stall_pop_count", pops, 4);

    // Full FIFO with ready raised exactly in the push cycle.
    reset = 1'b1; cycle_(); reset = 1'b0;
    ready = 1'b0;
    aud_l = 10'($urandom_range(0, 765));
    aud_r = 10'($urandom_range(0, 765));
    run_ticks(5, 1'b0, fc);
    cycle_();
    cycle_();
    ready = 1'b1;
    cycle_();
    ready = 1'b0;
    check_eq("full_pop_push_overflow", longint'(overflow_o), 0);
    check_eq("full_pop_push_valid", longint'(sample_valid_o), 1);
    ready = 1'b1;
    count_pops(10, pops);
    check_eq("full_pop_push_count", pops, 4);
    check_eq("full_pop_push_overflow_end", longint'(overflow_o), 0);

    // Converge on full scale, then mute.
    aud_l = 10'd765; aud_r = 10'd765;
    run_ticks(3, 1'b0, fc);
    mute = 1'b1;
    run_ticks(8, 1'b0, fc);
    mute = 1'b0;

    // Reset landing between a tick and its FIFO write.
    run_ticks(1, 1'b0, fc);
    cycle_();
    reset = 1'b1; cycle_(); reset = 1'b0;
    check_eq("midreset_valid", longint'(sample_valid_o), 0);
    check_eq("midreset_overflow", longint'(overflow_o), 0);
    run_ticks(1, 1'b0, fc);
    check_eq("midreset_next_tick", fc, 1125);

    // Random inputs and backpressure.
    run_ticks(10, 1'b1, fc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
